switch_debounce4: RTL and testbench
===================================

SWITCH_DEBOUNCE4 -- requirements
Module: switch_debounce4

Interface
REQ-001 SHALL have parameter WIDTH, default 4: number of independent switch channels.
REQ-002 SHALL have parameter CNT_BITS, default 16: per-channel stability counter width; MAX = 2^CNT_BITS-1.
REQ-003 SHALL have port CLK, input, 1: single clock, rising-edge.
REQ-004 SHALL have port RESETN, input, 1: reset, synchronous, active-low.
REQ-005 SHALL have port I, input, WIDTH: raw asynchronous switch levels (SWITCH[WIDTH-1:0]).
REQ-006 SHALL have port O, output, WIDTH: debounced levels, registered; feeds the downstream register's data input.
REQ-007 SHALL have port RISE, output, WIDTH: one-cycle pulse per channel on each O 0->1 transition.
REQ-008 SHALL have port FALL, output, WIDTH: one-cycle pulse per channel on each O 1->0 transition.
REQ-009 SHALL have port CHANGED, output, 1: OR of all RISE|FALL bits; usable as the downstream register's CE.

Function
REQ-010 SHALL pass each I bit through a two-flop synchronizer; S = second-stage output.
REQ-011 SHALL keep per channel a CNT_BITS-wide counter CNT and state bit O[k].
REQ-012 SHALL, per cycle with S[k]==O[k], clear CNT[k] to 0.
REQ-013 SHALL, per cycle with S[k]!=O[k] and CNT[k]<MAX, increment CNT[k] by 1; no wrap.
REQ-014 SHALL, per cycle with S[k]!=O[k] and CNT[k]==MAX, invert O[k] and clear CNT[k].
REQ-015 SHALL give latency: I[k] stable before edge 1 -> S[k] at edge 2 -> O[k] changes at edge 2+2^CNT_BITS.
REQ-016 SHALL discard any mismatch run shorter than 2^CNT_BITS synchronized cycles (glitch rejection); O unchanged, no pulses.
REQ-017 SHALL register RISE[k]/FALL[k] so they are high exactly in the cycle after the edge at which O[k] changes, low otherwise.
REQ-018 SHALL assert CHANGED in exactly the cycles where any RISE or FALL bit is high.
REQ-019 SHALL treat channels independently; simultaneous transitions on several channels SHALL produce their pulses in the same cycle.
REQ-020 SHALL never assert RISE[k] and FALL[k] together.

Reset
REQ-021 SHALL, while RESETN==0 at a rising CLK edge, clear synchronizer flops, all CNT, O, RISE, FALL, CHANGED to 0.
REQ-022 SHALL give reset priority over all other updates; partial counts at reset are discarded; counting restarts from 0 after release.
REQ-023 SHALL not require I to be stable during reset.

Configuration
REQ-024 SHALL use macro SWITCH_DEBOUNCE4_EDGE_DETECT_EN to include the edge-detect logic.
REQ-025 SHALL, with the macro defined, implement RISE, FALL, CHANGED per REQ-017..REQ-020.
REQ-026 SHALL, with the macro undefined, drive RISE, FALL, CHANGED constant 0, with no flops for them; O behaviour unchanged.

Verification (CNT_BITS=4, MAX=15, WIDTH=4, macro defined unless stated)
REQ-027 SHALL cover: RESETN=0 two cycles with I=4'hF, then release -> O=0 during reset; O=4'hF at 18th edge after release; RISE=4'hF, CHANGED=1 for exactly one cycle.
REQ-028 SHALL cover: from O=0, I[0]=1 for 10 cycles then 0 -> O stays 4'h0, RISE/FALL/CHANGED never asserted.
REQ-029 SHALL cover: I[1] toggling every 3 cycles for 30 cycles, then held 1 -> O[1] rises 18 edges after last I transition; exactly one RISE[1] pulse.
REQ-030 SHALL cover: from O=4'h4, same-cycle I[2]->0 and I[3]->1 -> after 18 edges O=4'h8, FALL=4'h4 and RISE=4'h8 in the same cycle, CHANGED=1 once.
REQ-031 SHALL cover: I=4'hF, RESETN=0 for one cycle 10 edges later -> O stays 0; O=4'hF at 18th edge after release.
REQ-032 SHALL cover: REQ-027 stimulus with macro undefined -> O identical; RISE, FALL, CHANGED 0 throughout.

Source files
------------

// File: rtl/switch_debounce4.sv
// Multi-channel switch debouncer: two-flop synchronizer, per-channel stability counter,
// optional registered RISE/FALL/CHANGED pulses enabled by SWITCH_DEBOUNCE4_EDGE_DETECT_EN.
module switch_debounce4 #(
    parameter int WIDTH    = 4,
    parameter int CNT_BITS = 16
) (
    input  logic             CLK,
    input  logic             RESETN,
    input  logic [WIDTH-1:0] I,
    output logic [WIDTH-1:0] O,
    output logic [WIDTH-1:0] RISE,
    output logic [WIDTH-1:0] FALL,
    output logic             CHANGED
);

    localparam logic [CNT_BITS-1:0] MAX = '1;

    logic [WIDTH-1:0]    sync_a;
    logic [WIDTH-1:0]    sync_b;
    logic [CNT_BITS-1:0] cnt [WIDTH];
    logic [WIDTH-1:0]    flip;

    // A channel flips only after a full run of MAX+1 mismatching synchronized cycles.
    always_comb begin
        flip = '0;
        for (int k = 0; k < WIDTH; k++) begin
            flip[k] = (sync_b[k] != O[k]) && (cnt[k] == MAX);
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            sync_a <= '0;
            sync_b <= '0;
            O      <= '0;
            for (int k = 0; k < WIDTH; k++) begin
                cnt[k] <= '0;
            end
        end else begin
            sync_a <= I;
            sync_b <= sync_a;
            for (int k = 0; k < WIDTH; k++) begin
                if (sync_b[k] == O[k]) begin
                    cnt[k] <= '0;
                end else if (cnt[k] == MAX) begin
                    O[k]   <= ~O[k];
                    cnt[k] <= '0;
                end else begin
                    cnt[k] <= cnt[k] + 1'b1;
                end
            end
        end
    end

`ifdef SWITCH_DEBOUNCE4_EDGE_DETECT_EN
    // Pulses are registered alongside O, so they appear in the cycle right after O changes.
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            RISE    <= '0;
            FALL    <= '0;
            CHANGED <= 1'b0;
        end else begin
            RISE    <= flip & ~O;
            FALL    <= flip & O;
            CHANGED <= |flip;
        end
    end
`else
    assign RISE    = '0;
    assign FALL    = '0;
    assign CHANGED = 1'b0;
`endif

endmodule

// File: tb/tb_switch_debounce4.sv
// Directed self-checking bench for switch_debounce4 with WIDTH=4, CNT_BITS=4 (MAX=15).
module tb_switch_debounce4;

`ifdef SWITCH_DEBOUNCE4_EDGE_DETECT_EN
    localparam bit EDGE_EN = 1'b1;
`else
    localparam bit EDGE_EN = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       RESETN = 1'b0;
    logic [3:0] I = 4'h0;
    logic [3:0] O;
    logic [3:0] RISE;
    logic [3:0] FALL;
    logic       CHANGED;

    int checks   = 0;
    int failures = 0;
    int overlap_cnt = 0;
    int changed_bad = 0;
    int pulse_cnt;
    int rise1_cnt;
    int o_bad;

    switch_debounce4 #(.WIDTH(4), .CNT_BITS(4)) dut (
        .CLK(CLK), .RESETN(RESETN), .I(I), .O(O),
        .RISE(RISE), .FALL(FALL), .CHANGED(CHANGED)
    );

    always #5 CLK = ~CLK;

    // Continuous invariants, judged at the end of the run.
    always @(negedge CLK) begin
        if (|(RISE & FALL)) overlap_cnt++;
        if (CHANGED !== |(RISE | FALL)) changed_bad++;
    end

    task automatic applyStimulus(input logic rn, input logic [3:0] iv, input int n);
        RESETN = rn;
        I = iv;
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #1;
        // Reset with all switches high, then release.
        applyStimulus(1'b0, 4'hF, 2);
        checkOutput("rst_O", O, 4'h0);
        checkOutput("rst_RISE", RISE, 4'h0);
        checkOutput("rst_CHANGED", CHANGED, 1'b0);
        applyStimulus(1'b1, 4'hF, 17);
        checkOutput("pwr_O_e17", O, 4'h0);
        applyStimulus(1'b1, 4'hF, 1);
        checkOutput("pwr_O_e18", O, 4'hF);
        checkOutput("pwr_RISE", RISE, EDGE_EN ? 4'hF : 4'h0);
        checkOutput("pwr_CHANGED", CHANGED, EDGE_EN ? 1'b1 : 1'b0);
        applyStimulus(1'b1, 4'hF, 1);
        checkOutput("pwr_RISE_end", RISE, 4'h0);
        checkOutput("pwr_CHANGED_end", CHANGED, 1'b0);
        checkOutput("pwr_O_hold", O, 4'hF);

        // Short glitch on channel 0 must be rejected.
        applyStimulus(1'b0, 4'h0, 2);
        pulse_cnt = 0;
        o_bad = 0;
        applyStimulus(1'b1, 4'h1, 1);
        for (int n = 0; n < 40; n++) begin
            if (n == 9) I = 4'h0;
            if (O !== 4'h0) o_bad++;
            if ((RISE | FALL) !== 4'h0 || CHANGED !== 1'b0) pulse_cnt++;
            applyStimulus(1'b1, I, 1);
        end
        checkOutput("glitch_O", O, 4'h0);
        checkOutput("glitch_O_cycles", o_bad, 0);
        checkOutput("glitch_pulses", pulse_cnt, 0);

        // Bouncing channel 1, then a steady high level.
        rise1_cnt = 0;
        for (int n = 0; n < 30; n++) begin
            I = ((n / 3) % 2 == 0) ? 4'h2 : 4'h0;
            applyStimulus(1'b1, I, 1);
            if (RISE[1]) rise1_cnt++;
        end
        checkOutput("bounce_O", O, 4'h0);
        applyStimulus(1'b1, 4'h2, 17);
        checkOutput("bounce_O_e17", O, 4'h0);
        applyStimulus(1'b1, 4'h2, 1);
        checkOutput("bounce_O_e18", O, 4'h2);
        if (RISE[1]) rise1_cnt++;
        for (int n = 0; n < 3; n++) begin
            applyStimulus(1'b1, 4'h2, 1);
            if (RISE[1]) rise1_cnt++;
        end
        checkOutput("bounce_rise1_count", rise1_cnt, EDGE_EN ? 1 : 0);

        // Bring O to 4'h4, then swap channels 2 and 3 in the same cycle.
        applyStimulus(1'b0, 4'h4, 2);
        applyStimulus(1'b1, 4'h4, 20);
        checkOutput("swap_O_start", O, 4'h4);
        applyStimulus(1'b1, 4'h8, 17);
        checkOutput("swap_O_e17", O, 4'h4);
        checkOutput("swap_CHANGED_e17", CHANGED, 1'b0);
        applyStimulus(1'b1, 4'h8, 1);
        checkOutput("swap_O_e18", O, 4'h8);
        checkOutput("swap_FALL", FALL, EDGE_EN ? 4'h4 : 4'h0);
        checkOutput("swap_RISE", RISE, EDGE_EN ? 4'h8 : 4'h0);
        checkOutput("swap_CHANGED", CHANGED, EDGE_EN ? 1'b1 : 1'b0);
        applyStimulus(1'b1, 4'h8, 1);
        checkOutput("swap_CHANGED_end", CHANGED, 1'b0);
        checkOutput("swap_pulses_end", {RISE, FALL}, 8'h00);

        // Mid-count reset discards partial progress.
        applyStimulus(1'b0, 4'h0, 2);
        applyStimulus(1'b1, 4'hF, 10);
        applyStimulus(1'b0, 4'hF, 1);
        checkOutput("midrst_O", O, 4'h0);
        applyStimulus(1'b1, 4'hF, 17);
        checkOutput("midrst_O_e17", O, 4'h0);
        applyStimulus(1'b1, 4'hF, 1);
        checkOutput("midrst_O_e18", O, 4'hF);
        checkOutput("midrst_RISE", RISE, EDGE_EN ? 4'hF : 4'h0);

        checkOutput("rise_fall_overlap", overlap_cnt, 0);
        checkOutput("changed_consistency", changed_bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
